// File: rtl/alu_arbiter_pkg.sv
// Shared op codes, FSM state encodings and widths for the two-port ALU arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: alu_op_e (3-bit op codes), state_e (arbiter FSM states),
// DATA_W / CNT_W widths.
package alu_arbiter_pkg;

    localparam int DATA_W = 32;
    // Wide enough for a settle count up to 15.
    localparam int CNT_W  = 4;

    typedef enum logic [2:0] {
        OP_ADD  = 3'd0,
        OP_SUB  = 3'd1,
        OP_XOR  = 3'd2,
        OP_SLT  = 3'd3,
        OP_AND  = 3'd4,
        OP_NAND = 3'd5,
        OP_NOR  = 3'd6,
        OP_OR   = 3'd7
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

endpackage : alu_arbiter_pkg

// File: rtl/alu_arbiter_alu.sv
// Purely combinational 32-bit ALU shared by both requesters of the arbiter.
// Latency: combinational; the caller waits a fixed number of cycles before sampling.
// Backpressure: none, outputs follow the inputs continuously.
//
// Ports:
//   i_op       op code (alu_op_e encoding)
//   i_a, i_b   operands
//   o_out      result
//   o_overflow signed overflow, only ever set for ADD and SUB
//   o_zero     high when o_out is all zeros
module alu_arbiter_alu
    import alu_arbiter_pkg::*;
(
    input  logic [2:0]        i_op,
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    output logic [DATA_W-1:0] o_out,
    output logic              o_overflow,
    output logic              o_zero
);

    logic [DATA_W-1:0] w_sum;
    logic [DATA_W-1:0] w_diff;
    logic              w_add_ovf;
    logic              w_sub_ovf;
    logic              w_slt;

    assign w_sum  = i_a + i_b;
    assign w_diff = i_a - i_b;

    // Two's-complement overflow: operands that push the result past the
    // sign boundary flip the result sign relative to operand a.
    assign w_add_ovf = (i_a[DATA_W-1] == i_b[DATA_W-1]) &&
                       (w_sum[DATA_W-1] != i_a[DATA_W-1]);
    assign w_sub_ovf = (i_a[DATA_W-1] != i_b[DATA_W-1]) &&
                       (w_diff[DATA_W-1] != i_a[DATA_W-1]);

    assign w_slt = ($signed(i_a) < $signed(i_b));

    always_comb begin
        o_out      = '0;
        o_overflow = 1'b0;
        case (i_op)
            OP_ADD: begin
                o_out      = w_sum;
                o_overflow = w_add_ovf;
            end
            OP_SUB: begin
                o_out      = w_diff;
                o_overflow = w_sub_ovf;
            end
            OP_XOR:  o_out = i_a ^ i_b;
            OP_SLT:  o_out = {{(DATA_W-1){1'b0}}, w_slt};
            OP_AND:  o_out = i_a & i_b;
            OP_NAND: o_out = ~(i_a & i_b);
            OP_NOR:  o_out = ~(i_a | i_b);
            OP_OR:   o_out = i_a | i_b;
            default: o_out = '0;
        endcase
    end

    assign o_zero = (o_out == '0);

endmodule : alu_arbiter_alu

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a single multi-cycle combinational ALU.
// Latency: rsp_valid rises exactly SETTLE_CYCLES cycles after the acceptance edge.
// Backpressure: one op in flight; ready is low outside IDLE and the response holds until rsp_ready.
//
// Ports:
//   clk, reset                      clock (rising edge), async active-high reset
//   reqN_valid/_ready/_op/_a/_b     requester N (N=0,1) valid-ready request channel
//   rsp_valid/_ready                response handshake
//   rsp_id/_result/_overflow/_zero  captured response payload
//   busy                            high whenever the FSM is not IDLE
// SETTLE_CYCLES (1..15) times the clk period must exceed the worst-case ALU
// propagation delay; the ALU path is treated as multicycle by the integrator.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 4
)
(
    input  logic              clk,
    input  logic              reset,

    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [2:0]        req0_op,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,

    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [2:0]        req1_op,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,

    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_result,
    output logic              rsp_overflow,
    output logic              rsp_zero,

    output logic              busy
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);

    // FSM and datapath state
    state_e            r_state;
    logic              r_ptr;
    logic [CNT_W-1:0]  r_cnt;
    logic [2:0]        r_op;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic              r_rsp_valid;
    logic              r_rsp_id;
    logic [DATA_W-1:0] r_rsp_result;
    logic              r_rsp_overflow;
    logic              r_rsp_zero;
    logic              r_busy;

    // Arbitration and ALU wires
    logic              w_grant_id;
    logic              w_idle;
    logic              w_accept;
    logic [2:0]        w_sel_op;
    logic [DATA_W-1:0] w_sel_a;
    logic [DATA_W-1:0] w_sel_b;
    logic [DATA_W-1:0] w_alu_out;
    logic              w_alu_ovf;
    logic              w_alu_zero;

    // Grant req1 when it is the only one asking, or when both ask and the
    // pointer favours it; otherwise the grant rests on req0.
    assign w_grant_id = req1_valid && (!req0_valid || r_ptr);
    assign w_idle     = (r_state == ST_IDLE);

    // Ready is gated by reset directly so it drops the instant reset rises,
    // not one edge later.
    assign req0_ready = w_idle && !w_grant_id && req0_valid && !reset;
    assign req1_ready = w_idle &&  w_grant_id && req1_valid && !reset;
    assign w_accept   = req0_ready || req1_ready;

    assign w_sel_op = w_grant_id ? req1_op : req0_op;
    assign w_sel_a  = w_grant_id ? req1_a  : req0_a;
    assign w_sel_b  = w_grant_id ? req1_b  : req0_b;

    // The ALU sees only the operand registers, so its inputs stay frozen for
    // the whole settle window regardless of what the requesters do.
    alu_arbiter_alu u_alu (
        .i_op       (r_op),
        .i_a        (r_a),
        .i_b        (r_b),
        .o_out      (w_alu_out),
        .o_overflow (w_alu_ovf),
        .o_zero     (w_alu_zero)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= ST_IDLE;
            r_ptr          <= 1'b0;
            r_cnt          <= '0;
            r_op           <= '0;
            r_a            <= '0;
            r_b            <= '0;
            r_rsp_valid    <= 1'b0;
            r_rsp_id       <= 1'b0;
            r_rsp_result   <= '0;
            r_rsp_overflow <= 1'b0;
            r_rsp_zero     <= 1'b0;
            r_busy         <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_op     <= w_sel_op;
                        r_a      <= w_sel_a;
                        r_b      <= w_sel_b;
                        // rsp_valid is low here, so the id can be recorded
                        // straight into the response register.
                        r_rsp_id <= w_grant_id;
                        r_cnt    <= CNT_LOAD;
                        r_busy   <= 1'b1;
                        r_state  <= ST_SETTLE;
                    end
                end

                ST_SETTLE: begin
                    // Counter starts at SETTLE_CYCLES-1, so the capture edge
                    // is exactly SETTLE_CYCLES edges after acceptance.
                    if (r_cnt == '0) begin
                        r_rsp_result   <= w_alu_out;
                        r_rsp_overflow <= w_alu_ovf;
                        r_rsp_zero     <= w_alu_zero;
                        r_rsp_valid    <= 1'b1;
                        r_state        <= ST_RESP;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end

                ST_RESP: begin
                    if (r_rsp_valid && rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        // Favour the other requester on the next tie.
                        r_ptr       <= ~r_rsp_id;
                        r_busy      <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end

                default: begin
                    r_rsp_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign rsp_valid    = r_rsp_valid;
    assign rsp_id       = r_rsp_id;
    assign rsp_result   = r_rsp_result;
    assign rsp_overflow = r_rsp_overflow;
    assign rsp_zero     = r_rsp_zero;
    assign busy         = r_busy;

endmodule : alu_arbiter

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: scoreboard of expected responses,
// filled on each observed acceptance and drained on each response handshake.
// Inputs are driven 1 time unit after posedge; DUT outputs are sampled on negedge.
module tb_alu_arbiter;
    import alu_arbiter_pkg::*;

    localparam int SETTLE = 4;

    typedef struct packed {
        logic        id;
        logic [31:0] res;
        logic        ovf;
        logic        zero;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [2:0]  req0_op, req1_op;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic        rsp_valid, rsp_ready, rsp_id;
    logic [31:0] rsp_result;
    logic        rsp_overflow, rsp_zero, busy;

    int   n_chk  = 0;
    int   n_pass = 0;
    int   cyc    = 0;
    int   acc_cyc = 0;
    bit   prev_vld = 0;
    exp_t sb[$];
    bit   order_q[$];

    alu_arbiter #(.SETTLE_CYCLES(SETTLE)) dut (
        .clk          (clk),
        .reset        (reset),
        .req0_valid   (req0_valid),
        .req0_ready   (req0_ready),
        .req0_op      (req0_op),
        .req0_a       (req0_a),
        .req0_b       (req0_b),
        .req1_valid   (req1_valid),
        .req1_ready   (req1_ready),
        .req1_op      (req1_op),
        .req1_a       (req1_a),
        .req1_b       (req1_b),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_id       (rsp_id),
        .rsp_result   (rsp_result),
        .rsp_overflow (rsp_overflow),
        .rsp_zero     (rsp_zero),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // Reference ALU in 64-bit signed arithmetic: overflow is any result
    // that does not survive truncation to 32 bits and sign re-extension.
    function automatic exp_t model(input logic id, input logic [2:0] op,
                                   input logic [31:0] a, input logic [31:0] b);
        exp_t   e;
        longint sa = longint'($signed(a));
        longint sb_v = longint'($signed(b));
        longint s = 0;
        e.id  = id;
        e.ovf = 1'b0;
        case (op)
            OP_ADD:  begin s = sa + sb_v; e.res = 32'(s); e.ovf = (s != longint'($signed(e.res))); end
            OP_SUB:  begin s = sa - sb_v; e.res = 32'(s); e.ovf = (s != longint'($signed(e.res))); end
            OP_XOR:  e.res = a ^ b;
            OP_SLT:  e.res = (sa < sb_v) ? 32'd1 : 32'd0;
            OP_AND:  e.res = a & b;
            OP_NAND: e.res = ~(a & b);
            OP_NOR:  e.res = ~(a | b);
            default: e.res = a | b;
        endcase
        e.zero = (e.res == 32'd0);
        return e;
    endfunction

    // Monitor: acceptances push, response handshakes pop and compare.
    always @(negedge clk) begin : mon
        exp_t e;
        if (reset) begin
            prev_vld = 1'b0;
        end else begin
            if (req0_valid && req0_ready) begin
                sb.push_back(model(1'b0, req0_op, req0_a, req0_b));
                acc_cyc = cyc + 1;
            end
            if (req1_valid && req1_ready) begin
                sb.push_back(model(1'b1, req1_op, req1_a, req1_b));
                acc_cyc = cyc + 1;
            end
            if (rsp_valid && !prev_vld) chk("latency", cyc - acc_cyc, SETTLE);
            if (rsp_valid && rsp_ready) begin
                if (sb.size() == 0) begin
                    chk("rsp_unexpected", rsp_valid, 1'b0);
                end else begin
                    e = sb.pop_front();
                    chk("rsp_id", rsp_id, e.id);
                    chk("rsp_result", rsp_result, e.res);
                    chk("rsp_overflow", rsp_overflow, e.ovf);
                    chk("rsp_zero", rsp_zero, e.zero);
                    order_q.push_back(rsp_id);
                end
            end
            prev_vld = rsp_valid;
        end
    end

    task automatic wait_accept(input bit id, output bit tmo);
        tmo = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (id ? (req1_valid && req1_ready) : (req0_valid && req0_ready)) begin
                tmo = 1'b0;
                break;
            end
        end
    endtask

    task automatic wait_drain(output bit tmo);
        tmo = 1'b1;
        for (int i = 0; i < 80; i++) begin
            @(posedge clk); #1;
            if (sb.size() == 0 && !rsp_valid) begin
                tmo = 1'b0;
                break;
            end
        end
    endtask

    task automatic do_op(input bit id, input logic [2:0] op,
                         input logic [31:0] a, input logic [31:0] b);
        bit tmo;
        @(posedge clk); #1;
        if (id) begin
            req1_op = op; req1_a = a; req1_b = b; req1_valid = 1'b1;
        end else begin
            req0_op = op; req0_a = a; req0_b = b; req0_valid = 1'b1;
        end
        wait_accept(id, tmo);
        chk("accept_timeout", tmo, 1'b0);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        wait_drain(tmo);
        chk("drain_timeout", tmo, 1'b0);
    endtask

    typedef struct packed {
        logic        id;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
    } vec_t;

    vec_t vecs[8];

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        bit   tmo;
        bit   seen;
        exp_t bp;

        // Reset with both requesters already valid (arbitration run follows).
        reset = 1'b1;
        req0_valid = 1'b1; req0_op = OP_ADD; req0_a = 32'd7;          req0_b = 32'd5;
        req1_valid = 1'b1; req1_op = OP_SUB; req1_a = 32'h8000_0000;  req1_b = 32'd1;
        rsp_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_rsp_valid", rsp_valid, 1'b0);
            chk("rst_rsp_id", rsp_id, 1'b0);
            chk("rst_rsp_result", rsp_result, 32'd0);
            chk("rst_rsp_ovf", rsp_overflow, 1'b0);
            chk("rst_rsp_zero", rsp_zero, 1'b0);
            chk("rst_busy", busy, 1'b0);
            chk("rst_req0_ready", req0_ready, 1'b0);
            chk("rst_req1_ready", req1_ready, 1'b0);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_req0_ready", req0_ready, 1'b1);
        chk("post_rst_req1_ready", req1_ready, 1'b0);

        // Both held valid: expect service order 0,1,0,1.
        tmo = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            if (order_q.size() >= 4) begin
                tmo = 1'b0;
                break;
            end
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        chk("arb_timeout", tmo, 1'b0);
        for (int i = 0; i < 4; i++)
            chk($sformatf("order%0d", i), order_q[i], i % 2);
        wait_drain(tmo);
        chk("drain_timeout", tmo, 1'b0);

        // Subtract to zero on req1.
        do_op(1'b1, OP_SUB, 32'd5, 32'd5);

        // Remaining op codes and sign/overflow corners.
        vecs[0] = '{1'b0, OP_AND,  32'hF0F0_1234, 32'h0FF0_FFFF};
        vecs[1] = '{1'b1, OP_NAND, 32'hFFFF_0000, 32'hFF00_FF00};
        vecs[2] = '{1'b0, OP_NOR,  32'h0000_00F0, 32'h0000_000F};
        vecs[3] = '{1'b1, OP_OR,   32'h1200_0000, 32'h0000_0034};
        vecs[4] = '{1'b0, OP_SLT,  32'hFFFF_FFFF, 32'd1};
        vecs[5] = '{1'b1, OP_SLT,  32'd5,         32'hFFFF_FFFD};
        vecs[6] = '{1'b0, OP_ADD,  32'h7FFF_FFFF, 32'd1};
        vecs[7] = '{1'b1, OP_XOR,  32'hA5A5_A5A5, 32'hA5A5_A5A5};
        foreach (vecs[i]) do_op(vecs[i].id, vecs[i].op, vecs[i].a, vecs[i].b);

        // Backpressure: hold response for 10 cycles while req1 waits.
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        req0_op = OP_XOR; req0_a = 32'hF0F0_F0F0; req0_b = 32'hFFFF_0000; req0_valid = 1'b1;
        bp = model(1'b0, OP_XOR, 32'hF0F0_F0F0, 32'hFFFF_0000);
        wait_accept(1'b0, tmo);
        chk("bp_accept_timeout", tmo, 1'b0);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_op = OP_OR; req1_a = 32'h0000_0F00; req1_b = 32'h0000_00F0; req1_valid = 1'b1;
        tmo = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                tmo = 1'b0;
                break;
            end
        end
        chk("bp_rsp_timeout", tmo, 1'b0);
        for (int i = 0; i < 10; i++) begin
            chk("bp_valid", rsp_valid, 1'b1);
            chk("bp_result", rsp_result, bp.res);
            chk("bp_id", rsp_id, 1'b0);
            chk("bp_zero", rsp_zero, bp.zero);
            chk("bp_busy", busy, 1'b1);
            chk("bp_req0_ready", req0_ready, 1'b0);
            chk("bp_req1_ready", req1_ready, 1'b0);
            @(negedge clk);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("bp_idle_busy", busy, 1'b0);
        chk("bp_idle_valid", rsp_valid, 1'b0);
        chk("bp_idle_req1_ready", req1_ready, 1'b1);
        @(posedge clk); #1;
        req1_valid = 1'b0;
        wait_drain(tmo);
        chk("drain_timeout", tmo, 1'b0);

        // Reset in the 2nd SETTLE cycle of SLT 3,5 aborts with no response.
        @(posedge clk); #1;
        req0_op = OP_SLT; req0_a = 32'd3; req0_b = 32'd5; req0_valid = 1'b1;
        wait_accept(1'b0, tmo);
        chk("mr_accept_timeout", tmo, 1'b0);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        sb.delete();
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        @(negedge clk);
        chk("mr_rsp_valid", rsp_valid, 1'b0);
        chk("mr_busy", busy, 1'b0);
        chk("mr_req0_ready", req0_ready, 1'b0);
        chk("mr_req1_ready", req1_ready, 1'b0);
        @(posedge clk); #1;
        reset = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < SETTLE + 4; i++) begin
            @(negedge clk);
            if (rsp_valid) seen = 1'b1;
        end
        chk("mr_no_rsp", seen, 1'b0);
        do_op(1'b0, OP_SLT, 32'd3, 32'd5);

        chk("sb_empty", sb.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule : tb_alu_arbiter
